intpol2_out_collector: RTL
==========================

// Module: intpol2_out_collector
// PURPOSE
//  Output-side sink for the 2x interpolator core: accepts interpolated I/Q sample pairs on the
//  core's write-enable strobe, buffers them, and drives almost-full back-pressure into the core's
//  Afull inputs. Host logic drains pairs over a 1-cycle-latency read port as packed 32-bit words.
//  Sits between the interpolator CORE outputs and the AIP/DMA read path.
// PARAMETERS
//  DATAPATH_WIDTH  12  sample width (signed two's complement) of I and Q
//  ADDR_WIDTH      3   buffer depth = 2**ADDR_WIDTH pairs
//  AF_DIFF         2   afull asserts when count >= DEPTH - AF_DIFF
//  DATA_WIDTH      32  host read word width
// PORTS
//  clk          in   1               single clock, all logic posedge
//  rst          in   1               synchronous, active-high reset
//  en_i         in   1               1 = RUN, 0 = writes ignored (reads still served)
//  clr_i        in   1               synchronous flush: pointers/count/flags to reset values
//  wr_en_i      in   1               core Write_Enable strobe, one pair per cycle
//  I_interp_i   in   DATAPATH_WIDTH  interpolated I sample
//  Q_interp_i   in   DATAPATH_WIDTH  interpolated Q sample
//  afull_I_o    out  1               back-pressure to core Afull_I input
//  afull_Q_o    out  1               back-pressure to core Afull_Q input (== afull_I_o)
//  rd_req_i     in   1               host pops one pair
//  rd_data_o    out  DATA_WIDTH      {sext16(I), sext16(Q)}
//  rd_valid_o   out  1               rd_data_o valid this cycle (1-cycle pulse)
//  empty_o      out  1               count == 0
//  count_o      out  ADDR_WIDTH+1    pairs stored, 0..DEPTH
//  overflow_o   out  1               sticky: write dropped because full
//  underflow_o  out  1               sticky: read requested while empty
//  thr_i        in   ADDR_WIDTH+1    irq threshold (only with LEVEL_IRQ_EN)
//  irq_o        out  1               level interrupt (only with LEVEL_IRQ_EN)
// BEHAVIOUR
//  Reset/clr: count=0, ptrs=0, empty_o=1, afull=0, rd_valid_o=0, rd_data_o=0, sticky flags=0, irq_o=0.
//  FSM: IDLE (en_i=0) <-> RUN (en_i=1), registered; transition takes effect the cycle after en_i change.
//   IDLE: wr_en_i ignored, not counted as overflow. RUN: wr_en_i writes pair at wr_ptr.
//  Write: accepted if !full, or full with same-cycle accepted read; else dropped, overflow_o<=1.
//  Read: rd_req_i with count>0 -> rd_data_o/rd_valid_o valid next cycle; rd_data_o holds between reads.
//   rd_req_i with count==0 -> ignored, underflow_o<=1; no fall-through: write+read on empty = write only.
//  Simultaneous accepted read+write: count unchanged. Pointers wrap modulo DEPTH; count never > DEPTH.
//  afull_I_o/afull_Q_o: combinational from registered count, (count >= DEPTH-AF_DIFF).
//  Packing: bits[31:16]=I sign-extended to 16b, bits[15:0]=Q sign-extended to 16b.
//  clr_i has priority over wr/rd in same cycle; rst has priority over clr_i. Reset mid-stream discards data.
// CONFIGURATION
//  INTPOL2_OUT_LEVEL_IRQ_EN defined: irq_o registered = (count >= thr_i) && thr_i!=0, RUN only.
//  Not defined: thr_i unused, irq_o tied 0; all other behaviour identical.
// STRUCTURE
//  Package intpol2_out_pkg: DEPTH/width localparams, state enum {ST_IDLE, ST_RUN}, pack function.
//  Sub-module intpol2_out_fifo_mem: 2*DATAPATH_WIDTH x DEPTH sync RAM, registered read port.
//  Top: FSM, pointers, count, flags, packing, optional irq.
// TESTING
//  1 rst, en=1, write I=12'h7FF,Q=12'h800, rd_req -> next cycle rd_data=32'h07FF_F800, rd_valid=1.
//  2 8 writes, no reads -> afull at count=6; 9th write dropped, overflow_o=1, count=8.
//  3 full, wr+rd same cycle -> count stays 8, oldest pair out, new pair stored at wrapped ptr.
//  4 empty, rd_req -> underflow_o=1, rd_valid stays 0; empty write+read -> count=1, no rd_valid.
//  5 count=5, clr_i=1 with wr_en -> count=0, empty=1, flags 0; en_i=0 writes ignored, no overflow.
//  6 LEVEL_IRQ_EN, thr=4: 4th write -> irq_o=1 next cycle; one read -> irq_o=0.

Source files
------------

// File: rtl/intpol2_out_pkg.sv
// Shared types and sizes for the 2x interpolator output collector.
// Holds buffer geometry, the host word width, the pair payload struct,
// the RUN/IDLE state enum and the host-word packing helper.
package intpol2_out_pkg;

   localparam int unsigned DATAPATH_WIDTH = 12;
   localparam int unsigned ADDR_WIDTH     = 3;
   localparam int unsigned DEPTH          = 2 ** ADDR_WIDTH;
   localparam int unsigned AF_DIFF        = 2;
   localparam int unsigned DATA_WIDTH     = 32;
   localparam int unsigned CNT_WIDTH      = ADDR_WIDTH + 1;
   localparam int unsigned HALF_WIDTH     = DATA_WIDTH / 2;
   localparam int unsigned EXT_WIDTH      = HALF_WIDTH - DATAPATH_WIDTH;
   localparam int unsigned PAIR_WIDTH     = 2 * DATAPATH_WIDTH;

   // One interpolated I/Q pair as stored in the buffer
   typedef struct packed {
      logic [DATAPATH_WIDTH-1:0] i;
      logic [DATAPATH_WIDTH-1:0] q;
   } pair_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   // Host word: I sign-extended in the upper half, Q sign-extended in the lower half
   function automatic logic [DATA_WIDTH-1:0] pack_pair(input pair_t p);
      return {{EXT_WIDTH{p.i[DATAPATH_WIDTH-1]}}, p.i,
              {EXT_WIDTH{p.q[DATAPATH_WIDTH-1]}}, p.q};
   endfunction

endpackage

// File: rtl/intpol2_out_fifo_mem.sv
// Pair storage: DEPTH x (2*DATAPATH_WIDTH) synchronous RAM with a registered read port.
// Ports:
//   clk, rst      clock and synchronous active-high reset (read register only)
//   clr_i         synchronous clear of the read register
//   we_i/waddr_i/wdata_i   write port
//   re_i/raddr_i           read request; rdata_o updates on the next edge and holds otherwise
//   rdata_o       registered read data
// A read and write to the same address in one cycle returns the old contents.
module intpol2_out_fifo_mem
   import intpol2_out_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr_i,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] waddr_i,
   input  pair_t                 wdata_i,
   input  logic                  re_i,
   input  logic [ADDR_WIDTH-1:0] raddr_i,
   output pair_t                 rdata_o
);

   pair_t mem_q [DEPTH];
   pair_t rdata_q;

   // Storage array, no reset needed
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Read register: cleared by reset/flush, otherwise holds between reads
   always_ff @(posedge clk) begin
      if (rst || clr_i) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/intpol2_out_collector.sv
// Output-side sink for the 2x interpolator core. Buffers I/Q pairs written on the
// core's write strobe, raises almost-full back-pressure, and serves packed 32-bit
// words to the host over a 1-cycle-latency read port.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   en_i                     1 = RUN (writes accepted), 0 = IDLE; takes effect next cycle
//   clr_i                    synchronous flush of pointers, count, flags, read data
//   wr_en_i, I_interp_i, Q_interp_i   pair write from the core
//   afull_I_o, afull_Q_o     almost-full back-pressure (identical)
//   rd_req_i                 host pop; rd_data_o/rd_valid_o valid next cycle
//   rd_data_o, rd_valid_o    packed pair and its 1-cycle valid pulse
//   empty_o, count_o         occupancy
//   overflow_o, underflow_o  sticky error flags
//   thr_i, irq_o             level interrupt (active only with INTPOL2_OUT_LEVEL_IRQ_EN)
// Build option: define INTPOL2_OUT_LEVEL_IRQ_EN to enable the level interrupt;
// otherwise thr_i is ignored and irq_o is tied low.
module intpol2_out_collector
   import intpol2_out_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en_i,
   input  logic                      clr_i,
   input  logic                      wr_en_i,
   input  logic [DATAPATH_WIDTH-1:0] I_interp_i,
   input  logic [DATAPATH_WIDTH-1:0] Q_interp_i,
   output logic                      afull_I_o,
   output logic                      afull_Q_o,
   input  logic                      rd_req_i,
   output logic [DATA_WIDTH-1:0]     rd_data_o,
   output logic                      rd_valid_o,
   output logic                      empty_o,
   output logic [CNT_WIDTH-1:0]      count_o,
   output logic                      overflow_o,
   output logic                      underflow_o,
   input  logic [CNT_WIDTH-1:0]      thr_i,
   output logic                      irq_o
);

   localparam logic [CNT_WIDTH-1:0] CNT_FULL  = CNT_WIDTH'(DEPTH);
   localparam logic [CNT_WIDTH-1:0] CNT_AFULL = CNT_WIDTH'(DEPTH - AF_DIFF);

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_WIDTH-1:0]  count_q, count_d;
   logic                  ovf_q, ovf_d;
   logic                  unf_q, unf_d;
   logic                  rd_valid_q, rd_valid_d;

   logic                  full_c;
   logic                  wr_try_c;
   logic                  wr_acc_c;
   logic                  rd_acc_c;
   pair_t                 wr_pair_c;
   pair_t                 rd_pair_c;

   // Mode FSM: follows en_i one cycle later
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (en_i)  state_d = ST_RUN;
         ST_RUN:  if (!en_i) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Handshake decode; flush suppresses all traffic in its cycle
   always_comb begin
      full_c   = (count_q == CNT_FULL);
      rd_acc_c = !clr_i && rd_req_i && (count_q != '0);
      wr_try_c = !clr_i && wr_en_i && (state_q == ST_RUN);
      // a full buffer still takes a write if a read frees a slot this cycle
      wr_acc_c = wr_try_c && (!full_c || rd_acc_c);
   end

   // Pointer, count and flag next-state
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      ovf_d      = ovf_q;
      unf_d      = unf_q;
      rd_valid_d = 1'b0;

      if (clr_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         ovf_d    = 1'b0;
         unf_d    = 1'b0;
      end else begin
         if (wr_acc_c) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
         end
         if (rd_acc_c) begin
            rd_ptr_d   = rd_ptr_q + ADDR_WIDTH'(1);
            rd_valid_d = 1'b1;
         end
         case ({wr_acc_c, rd_acc_c})
            2'b10:   count_d = count_q + CNT_WIDTH'(1);
            2'b01:   count_d = count_q - CNT_WIDTH'(1);
            default: count_d = count_q;
         endcase
         if (wr_try_c && !wr_acc_c) begin
            ovf_d = 1'b1;
         end
         if (rd_req_i && (count_q == '0)) begin
            unf_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
         rd_valid_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         ovf_q      <= ovf_d;
         unf_q      <= unf_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign wr_pair_c = '{i: I_interp_i, q: Q_interp_i};

   intpol2_out_fifo_mem u_mem (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (clr_i),
      .we_i    (wr_acc_c),
      .waddr_i (wr_ptr_q),
      .wdata_i (wr_pair_c),
      .re_i    (rd_acc_c),
      .raddr_i (rd_ptr_q),
      .rdata_o (rd_pair_c)
   );

   // Outputs are pure wiring/decode of registered state
   assign rd_data_o   = pack_pair(rd_pair_c);
   assign rd_valid_o  = rd_valid_q;
   assign count_o     = count_q;
   assign empty_o     = (count_q == '0);
   assign afull_I_o   = (count_q >= CNT_AFULL);
   assign afull_Q_o   = afull_I_o;
   assign overflow_o  = ovf_q;
   assign underflow_o = unf_q;

`ifdef INTPOL2_OUT_LEVEL_IRQ_EN
   logic irq_q, irq_d;

   // Level irq tracks the occupancy being loaded this edge, RUN mode only
   always_comb begin
      irq_d = 1'b0;
      if (!clr_i && (state_q == ST_RUN) && (thr_i != '0)) begin
         irq_d = (count_d >= thr_i);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= irq_d;
      end
   end

   assign irq_o = irq_q;
`else
   logic unused_thr;
   assign unused_thr = ^thr_i;
   assign irq_o      = 1'b0;
`endif

endmodule
